// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared types and constants for the factorial datapath
package fact_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational unsigned adder, counterpart of the subtractor
module adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // The shift-and-add product never exceeds WIDTH bits, so no carry out is kept
    assign sum = a + b;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-and-add unsigned multiplier, one bit per clock
module seq_multiplier
    import fact_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    mul_state_t             state_q, state_d;
    logic [2*WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]       mult_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0]       product_q;
    logic                   overflow_q;

    logic                   accept;
    logic                   step;
    logic                   finish;
    logic [2*WIDTH-1:0]     sum;
    logic [2*WIDTH-1:0]     acc_d;

    adder #(
        .WIDTH (2*WIDTH)
    ) u_adder (
        .a   (acc_q),
        .b   (mcand_q),
        .sum (sum)
    );

    assign acc_d = mult_q[0] ? sum : acc_q;

    // Next-state logic: accept a request from IDLE or DONE, iterate WIDTH times in RUN
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shift registers, accumulator, counter and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q    <= '0;
            mult_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            mcand_q <= {{WIDTH{1'b0}}, a};
            mult_q  <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            mult_q  <= mult_q >> 1;
            // Counter returns to zero on the last iteration instead of wrapping
            cnt_q   <= finish ? '0 : cnt_q + CNT_W'(1);
            if (finish) begin
                product_q  <= acc_d[WIDTH-1:0];
                overflow_q <= |acc_d[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] product;
    logic         overflow;

    int checks;
    int errors;
    int both_high;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be high together
    always @(negedge clk) if (busy && done) both_high++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full 64-bit product, low half plus any-nonzero high half
    function automatic logic [W:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] full;
        full = 64'(x) * 64'(y);
        return {|full[2*W-1:W], full[W-1:0]};
    endfunction

    // Issue one operation from a negedge; optionally pulse start while busy
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input bit noisy, input string tag);
        logic [W:0] exp_r;
        int lat;
        int busy_cnt;
        int extra;
        exp_r    = ref_mul(op_a, op_b);
        a        = op_a;
        b        = op_b;
        start    = 1'b1;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (noisy && (k == 5 || k == 20)) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            if (noisy && (k == 6 || k == 21)) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, "_product"}, 64'(product), 64'(exp_r[W-1:0]));
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_r[W]));
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({tag, "_single_done"}, 64'(extra), 64'(0));
        check({tag, "_held"}, 64'(product), 64'(exp_r[W-1:0]));
    endtask

    initial begin
        int dones;
        int done_k[$];
        logic [W:0] exp_r;
        checks    = 0;
        errors    = 0;
        both_high = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd5, 32'd4, 1'b0, "mul5x4");
        run_op(32'h1C8CFC00, 32'd13, 1'b0, "f12x13");
        check("f12x13_const", 64'(product), 64'h7328CC00);
        check("f12x13_ovf_const", 64'(overflow), 64'(1));
        run_op(32'h1C8CFC00, 32'd1, 1'b0, "f12x1");
        run_op(32'hFFFFFFFF, 32'd0, 1'b0, "ffx0");
        run_op(32'd0, 32'hFFFFFFFF, 1'b0, "0xff");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "ffxff");

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom_range(0, 20) : $urandom;
            run_op(ra, rb, 1'b0, "rand");
        end

        run_op(32'd1234567, 32'd89, 1'b1, "ignore_start");

        // Reset asserted mid-RUN aborts without a done pulse
        a     = 32'd77;
        b     = 32'd99;
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_product", 64'(product), 64'(0));
        check("abort_overflow", 64'(overflow), 64'(0));
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3) rst_n = 1'b1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        run_op(32'd77, 32'd99, 1'b0, "after_abort");

        // Continuous start: back-to-back operations every W+1 cycles
        exp_r = ref_mul(32'd3, 32'd7);
        a     = 32'd3;
        b     = 32'd7;
        start = 1'b1;
        for (int k = 0; k < 200 && done_k.size() < 4; k++) begin
            @(negedge clk);
            if (done) begin
                done_k.push_back(k);
                check("b2b_product", 64'(product), 64'(exp_r[W-1:0]));
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(done_k.size()), 64'(4));
        for (int i = 1; i < done_k.size(); i++)
            check("b2b_interval", 64'(done_k[i] - done_k[i-1]), 64'(W + 1));
        repeat (40) @(negedge clk);
        check("busy_done_exclusive", 64'(both_high), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
